// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I integer core: combinational decode/execute/memory/writeback,
// with the register file, pc and data-RAM store all committing on the rising clock edge.
module rv32i_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] memory_address,
    input  logic [31:0] memory_out,
    output logic [31:0] memory_write,
    output logic [3:0]  memory_byte_enable,
    output logic        memory_we,
    output logic        ebreak
);
    localparam logic [6:0]  OP_LUI      = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC    = 7'b0010111;
    localparam logic [6:0]  OP_JAL      = 7'b1101111;
    localparam logic [6:0]  OP_JALR     = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam logic [6:0]  OP_LOAD     = 7'b0000011;
    localparam logic [6:0]  OP_STORE    = 7'b0100011;
    localparam logic [6:0]  OP_IMM      = 7'b0010011;
    localparam logic [6:0]  OP_REG      = 7'b0110011;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    logic [31:0] r_pc;
    logic [31:0] r_regs [32];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val, w_alu_b, w_alu;
    logic [31:0] w_addr, w_next_pc, w_rd_data, w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [3:0]  w_be;
    logic        w_rd_we, w_we, w_take, w_ebreak;

    assign w_opcode  = instruction[6:0];
    assign w_rd      = instruction[11:7];
    assign w_funct3  = instruction[14:12];
    assign w_rs1     = instruction[19:15];
    assign w_rs2     = instruction[24:20];
    assign w_imm_i   = {{20{instruction[31]}}, instruction[31:20]};
    assign w_imm_s   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign w_imm_b   = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_u   = {instruction[31:12], 12'b0};
    assign w_imm_j   = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
    assign w_ebreak  = (instruction == EBREAK_INSN);

    // Entry 0 is cleared on reset and never written, so x0 always reads zero.
    assign w_rs1_val = r_regs[w_rs1];
    assign w_rs2_val = r_regs[w_rs2];

    // Shared ALU for OP and OP-IMM; bit 30 selects SUB (register form only) and SRA/SRAI.
    assign w_alu_b = (w_opcode == OP_REG) ? w_rs2_val : w_imm_i;
    assign w_shamt = w_alu_b[4:0];
    always_comb begin
        case (w_funct3)
            3'b000:  w_alu = (w_opcode == OP_REG && instruction[30]) ? w_rs1_val - w_alu_b
                                                                     : w_rs1_val + w_alu_b;
            3'b001:  w_alu = w_rs1_val << w_shamt;
            3'b010:  w_alu = {31'b0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'b011:  w_alu = {31'b0, w_rs1_val < w_alu_b};
            3'b100:  w_alu = w_rs1_val ^ w_alu_b;
            3'b101:  w_alu = instruction[30] ? 32'($signed(w_rs1_val) >>> w_shamt)
                                             : w_rs1_val >> w_shamt;
            3'b110:  w_alu = w_rs1_val | w_alu_b;
            default: w_alu = w_rs1_val & w_alu_b;
        endcase
    end

    always_comb begin
        case (w_addr[1:0])
            2'd0:    w_ld_byte = memory_out[7:0];
            2'd1:    w_ld_byte = memory_out[15:8];
            2'd2:    w_ld_byte = memory_out[23:16];
            default: w_ld_byte = memory_out[31:24];
        endcase
        w_ld_half = w_addr[1] ? memory_out[31:16] : memory_out[15:0];
    end

    // Decode/execute: next pc, writeback value and store lanes for the current instruction.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        w_rd_we   = 1'b0;
        w_rd_data = '0;
        w_addr    = '0;
        w_we      = 1'b0;
        w_be      = '0;
        w_wdata   = '0;
        w_take    = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_rd_we   = 1'b1;
                w_rd_data = w_imm_u;
            end
            OP_AUIPC: begin
                w_rd_we   = 1'b1;
                w_rd_data = r_pc + w_imm_u;
            end
            OP_JAL: begin
                w_rd_we   = 1'b1;
                w_rd_data = r_pc + 32'd4;
                w_next_pc = r_pc + w_imm_j;
            end
            OP_JALR: begin
                w_rd_we   = 1'b1;
                w_rd_data = r_pc + 32'd4;
                w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                case (w_funct3)
                    3'b000:  w_take = (w_rs1_val == w_rs2_val);
                    3'b001:  w_take = (w_rs1_val != w_rs2_val);
                    3'b100:  w_take = ($signed(w_rs1_val) < $signed(w_rs2_val));
                    3'b101:  w_take = ($signed(w_rs1_val) >= $signed(w_rs2_val));
                    3'b110:  w_take = (w_rs1_val < w_rs2_val);
                    3'b111:  w_take = (w_rs1_val >= w_rs2_val);
                    default: w_take = 1'b0;
                endcase
                if (w_take) w_next_pc = r_pc + w_imm_b;
            end
            OP_LOAD: begin
                w_addr  = w_rs1_val + w_imm_i;
                w_rd_we = 1'b1;
                case (w_funct3)
                    3'b000:  w_rd_data = {{24{w_ld_byte[7]}}, w_ld_byte};
                    3'b001:  w_rd_data = {{16{w_ld_half[15]}}, w_ld_half};
                    3'b010:  w_rd_data = memory_out;
                    3'b100:  w_rd_data = {24'b0, w_ld_byte};
                    3'b101:  w_rd_data = {16'b0, w_ld_half};
                    default: w_rd_we   = 1'b0;
                endcase
            end
            OP_STORE: begin
                w_addr = w_rs1_val + w_imm_s;
                w_we   = 1'b1;
                case (w_funct3)
                    3'b000: begin
                        w_be    = 4'(4'b0001 << w_addr[1:0]);
                        w_wdata = {4{w_rs2_val[7:0]}};
                    end
                    3'b001: begin
                        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                        w_wdata = {2{w_rs2_val[15:0]}};
                    end
                    3'b010: begin
                        w_be    = 4'b1111;
                        w_wdata = w_rs2_val;
                    end
                    default: w_we = 1'b0;
                endcase
            end
            OP_IMM, OP_REG: begin
                w_rd_we   = 1'b1;
                w_rd_data = w_alu;
            end
            default: ;
        endcase
        if (w_ebreak) w_next_pc = r_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_next_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_rd_we && w_rd != 5'd0) begin
            r_regs[w_rd] <= w_rd_data;
        end
    end

    assign pc                 = r_pc;
    assign memory_address     = w_addr;
    assign memory_write       = w_wdata;
    assign memory_byte_enable = rst ? 4'b0000 : w_be;
    assign memory_we          = w_we & ~rst;
    assign ebreak             = w_ebreak;
endmodule

// File: tb/tb_rv32i_cpu.sv
// Program-driven bench: small programs run on the core and their stores are scored
// against expected (address, data, byte-enable) triples queued when the program is loaded.
module tb_rv32i_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction, pc, memory_address, memory_out, memory_write;
    logic [3:0]  memory_byte_enable;
    logic        memory_we, ebreak;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } store_t;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] EBRK  = 32'h0010_0073;

    logic [31:0] rom [256];
    logic [31:0] ram [256];
    store_t      sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    rv32i_cpu #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
        .memory_address(memory_address), .memory_out(memory_out),
        .memory_write(memory_write), .memory_byte_enable(memory_byte_enable),
        .memory_we(memory_we), .ebreak(ebreak)
    );

    always #5 clk = ~clk;

    assign instruction = rom[pc[9:2]];
    assign memory_out  = ram[memory_address[9:2]];

    always @(posedge clk) begin
        if (memory_we) begin
            for (int b = 0; b < 4; b++)
                if (memory_byte_enable[b]) ram[memory_address[9:2]][b*8 +: 8] <= memory_write[b*8 +: 8];
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Store monitor: every DUT store must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (memory_we) begin
                if (sb_q.size() == 0) begin
                    check_vec("unexpected_store", memory_address, 32'hFFFF_FFFF);
                end else begin
                    store_t e;
                    e = sb_q.pop_front();
                    check_vec("st_addr", memory_address, e.addr);
                    check_vec("st_data", memory_write, e.data);
                    check_vec("st_be", 32'(memory_byte_enable), 32'(e.be));
                end
            end else begin
                check_vec("idle_be", 32'(memory_byte_enable), 32'h0);
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_s(imm, rs2, rs1, 3'b010);
    endfunction
    function automatic logic [31:0] ld(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
        return enc_i(imm, rs1, f3, rd, 7'b0000011);
    endfunction

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        store_t e;
        e.addr = a; e.data = d; e.be = be;
        sb_q.push_back(e);
    endtask

    // Enter reset and blank the ROM; the caller loads its program while reset is held.
    task automatic begin_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = NOP;
    endtask

    task automatic end_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_ebreak(input logic [31:0] exp_pc);
        for (int i = 0; i < 300 && !ebreak; i++) @(negedge clk);
        check_vec("ebreak_seen", 32'(ebreak), 32'h1);
        check_vec("ebreak_pc", pc, exp_pc);
        repeat (3) @(negedge clk);
        check_vec("halt_pc", pc, exp_pc);
        check_vec("halt_ebreak", 32'(ebreak), 32'h1);
        check_vec("sb_drained", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] alu_exp [12];

        // Reset behaviour and sequential fetch.
        begin_reset();
        repeat (2) @(negedge clk);
        check_vec("rst_pc", pc, 32'h0);
        check_vec("rst_we", 32'(memory_we), 32'h0);
        rst = 1'b0;
        #1 check_vec("rel_pc0", pc, 32'h0);
        @(negedge clk); check_vec("rel_pc4", pc, 32'h4);
        @(negedge clk); check_vec("rel_pc8", pc, 32'h8);

        // ALU operations, results spilled to RAM for observation.
        begin_reset();
        rom[0]  = addi(5'd1, 5'd0, 12'd5);
        rom[1]  = addi(5'd2, 5'd0, 12'hFFD);
        rom[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        rom[3]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4);
        rom[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5);
        rom[5]  = enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6);
        rom[6]  = enc_i({7'h20, 5'd1}, 5'd2, 3'b101, 5'd7, 7'b0010011);
        rom[7]  = enc_i(12'd3, 5'd1, 3'b001, 5'd8, 7'b0010011);
        rom[8]  = enc_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd9);
        rom[9]  = enc_i(12'h0F0, 5'd2, 3'b100, 5'd10, 7'b0010011);
        rom[10] = enc_r(7'h00, 5'd1, 5'd2, 3'b111, 5'd11);
        rom[11] = enc_r(7'h00, 5'd8, 5'd1, 3'b110, 5'd12);
        rom[12] = {20'h00001, 5'd13, 7'b0010111};
        rom[13] = enc_r(7'h20, 5'd1, 5'd2, 3'b101, 5'd14);
        alu_exp = '{32'h2, 32'hFFFF_FFF8, 32'h1, 32'h0, 32'hFFFF_FFFE, 32'd40,
                    32'h07FF_FFFF, 32'hFFFF_FF0D, 32'h5, 32'h2D, 32'h1030, 32'hFFFF_FFFF};
        for (int k = 0; k < 12; k++) begin
            rom[14 + k] = sw(5'(3 + k), 5'd0, 12'(4 * k));
            expect_store(32'(4 * k), alu_exp[k], 4'b1111);
        end
        rom[26] = EBRK;
        end_reset();
        run_to_ebreak(32'h68);

        // Loads and stores of every width and lane.
        begin_reset();
        rom[0]  = addi(5'd1, 5'd0, 12'h080);
        rom[1]  = {20'h12345, 5'd2, 7'b0110111};
        rom[2]  = sw(5'd2, 5'd1, 12'd0);
        rom[3]  = enc_s(12'd1, 5'd0, 5'd1, 3'b000);
        rom[4]  = ld(3'b000, 5'd3, 5'd1, 12'd3);
        rom[5]  = ld(3'b101, 5'd4, 5'd1, 12'd0);
        rom[6]  = addi(5'd5, 5'd0, 12'hFFF);
        rom[7]  = enc_s(12'd6, 5'd5, 5'd1, 3'b001);
        rom[8]  = ld(3'b001, 5'd6, 5'd1, 12'd6);
        rom[9]  = ld(3'b100, 5'd7, 5'd1, 12'd6);
        rom[10] = ld(3'b010, 5'd8, 5'd1, 12'd0);
        rom[11] = ld(3'b000, 5'd9, 5'd1, 12'd7);
        rom[12] = sw(5'd3, 5'd0, 12'h040);
        rom[13] = sw(5'd4, 5'd0, 12'h044);
        rom[14] = sw(5'd6, 5'd0, 12'h048);
        rom[15] = sw(5'd7, 5'd0, 12'h04C);
        rom[16] = sw(5'd8, 5'd0, 12'h050);
        rom[17] = sw(5'd9, 5'd0, 12'h054);
        rom[18] = EBRK;
        expect_store(32'h80, 32'h1234_5000, 4'b1111);
        expect_store(32'h81, 32'h0,         4'b0010);
        expect_store(32'h86, 32'hFFFF_FFFF, 4'b1100);
        expect_store(32'h40, 32'h12,        4'b1111);
        expect_store(32'h44, 32'h0,         4'b1111);
        expect_store(32'h48, 32'hFFFF_FFFF, 4'b1111);
        expect_store(32'h4C, 32'hFF,        4'b1111);
        expect_store(32'h50, 32'h1234_0000, 4'b1111);
        expect_store(32'h54, 32'hFFFF_FFFF, 4'b1111);
        end_reset();
        run_to_ebreak(32'h48);

        // Branches and jumps; skipped slots hold stores that must never appear.
        begin_reset();
        rom[0]  = addi(5'd5, 5'd0, 12'hFFF);
        rom[1]  = addi(5'd6, 5'd0, 12'd1);
        rom[2]  = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
        rom[3]  = sw(5'd5, 5'd0, 12'h0F0);
        rom[4]  = enc_j(21'd8, 5'd1);
        rom[5]  = enc_j(21'd16, 5'd0);
        rom[6]  = sw(5'd1, 5'd0, 12'h060);
        rom[7]  = enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111);
        rom[8]  = sw(5'd5, 5'd0, 12'h0F4);
        rom[9]  = enc_b(13'd8, 5'd6, 5'd5, 3'b110);
        rom[10] = sw(5'd6, 5'd0, 12'h068);
        rom[11] = enc_b(13'd8, 5'd6, 5'd5, 3'b100);
        rom[12] = sw(5'd5, 5'd0, 12'h0F8);
        rom[13] = enc_b(13'd8, 5'd6, 5'd5, 3'b001);
        rom[14] = sw(5'd5, 5'd0, 12'h0FC);
        rom[15] = enc_b(13'd8, 5'd5, 5'd6, 3'b101);
        rom[16] = sw(5'd5, 5'd0, 12'h0E0);
        rom[17] = enc_b(13'd8, 5'd5, 5'd6, 3'b111);
        rom[18] = sw(5'd6, 5'd0, 12'h070);
        rom[19] = enc_i(12'h041, 5'd1, 3'b000, 5'd7, 7'b1100111);
        rom[20] = sw(5'd5, 5'd0, 12'h0E4);
        rom[21] = sw(5'd7, 5'd0, 12'h074);
        rom[22] = EBRK;
        expect_store(32'h60, 32'h14, 4'b1111);
        expect_store(32'h68, 32'h1,  4'b1111);
        expect_store(32'h70, 32'h1,  4'b1111);
        expect_store(32'h74, 32'h50, 4'b1111);
        end_reset();
        run_to_ebreak(32'h58);

        // x0 is immutable; EBREAK at 0x20 halts.
        begin_reset();
        rom[0] = addi(5'd0, 5'd0, 12'd7);
        rom[1] = sw(5'd0, 5'd0, 12'h078);
        rom[8] = EBRK;
        expect_store(32'h78, 32'h0, 4'b1111);
        end_reset();
        run_to_ebreak(32'h20);

        // Asynchronous reset while a store is on the bus.
        begin_reset();
        rom[0] = addi(5'd1, 5'd0, 12'd9);
        rom[2] = sw(5'd1, 5'd0, 12'h07C);
        end_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_vec("async_pc", pc, 32'h0);
        check_vec("async_we", 32'(memory_we), 32'h0);
        begin_reset();
        rom[0] = sw(5'd1, 5'd0, 12'h07C);
        rom[1] = EBRK;
        expect_store(32'h7C, 32'h0, 4'b1111);
        end_reset();
        run_to_ebreak(32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
